io_bus_arbiter: RTL

Shares the single IO peripheral bus (address window 0x40000xxx) between multiple bus masters: the CPU memory stage, the bootloader and any future DMA engine. It grants one master at a time using registered round-robin arbitration and forwards that master's strobes, address and write data to the peripheral side. It returns the peripheral's read data and acknowledge to the granted master. An optional watchdog terminates transactions that no peripheral acknowledges, so the CPU `stall_mem` path cannot hang forever.

---
 rtl/io_bus_pkg.sv | 13 +
 rtl/io_bus_arbiter_rr.sv | 33 +++
 rtl/io_bus_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO peripheral bus arbiter and the memory stage.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam logic [19:0] IO_MEM_SPACE = 20'h40000;
    localparam logic [31:0] IO_ERR_DATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = (IW+1)'(ptr_i) + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o                  = 1'b1;
                grant_o[cand[IW-1:0]]    = 1'b1;
                idx_o                    = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO peripheral bus between several masters.
// Optional no-ack watchdog is built when IO_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ARB_IDLE | no grant; pick next requester from rr_ptr
// ARB_BUSY | granted master mirrored onto s_*, waiting for ack (or timeout)
// ARB_DONE | one dead cycle so the acked master can drop its request
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = IO_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    input  logic [NUM_MASTERS-1:0]    m_read_i,
    input  logic [NUM_MASTERS-1:0]    m_write_i,
    output logic [31:0]               m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    output logic                      s_read_o,
    output logic                      s_write_o,
    input  logic [31:0]               s_rdata_i,
    input  logic                      s_ack_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      busy_o,
    output logic                      timeout_err_o,
    input  logic                      err_clr_i
);

    localparam int IW = $clog2(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_valid;

    logic        in_busy;
    logic        g_read;
    logic        g_write;
    logic        g_active;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        ack_hit;
    logic        to_hit;
    logic        xfer_done;

    assign req = m_read_i | m_write_i;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign in_busy   = (state_q == ARB_BUSY);
    assign g_read    = m_read_i[gidx_q];
    assign g_write   = m_write_i[gidx_q];
    assign g_active  = in_busy & (g_read | g_write);
    assign g_addr    = m_addr_i[{gidx_q, 5'd0} +: 32];
    assign g_wdata   = m_wdata_i[{gidx_q, 5'd0} +: 32];
    // An aborting master (both strobes low) never sees an ack, even if s_ack_i is high.
    assign ack_hit   = g_active & s_ack_i;
    assign xfer_done = ack_hit | to_hit;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;

    assign to_hit = g_active & ~s_ack_i & (tmr_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmr_d = in_busy ? tmr_q + CW'(1) : '0;
        err_d = err_q;
        if (to_hit) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign timeout_err_o = err_q;
`else
    logic unused_cfg;

    assign to_hit        = 1'b0;
    assign timeout_err_o = 1'b0;
    assign unused_cfg    = err_clr_i | (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        s_read_o  = g_active & g_read & ~g_write;
        s_write_o = g_active & g_write;
        s_addr_o  = in_busy ? g_addr  : '0;
        s_wdata_o = in_busy ? g_wdata : '0;
        grant_o   = in_busy ? grant_q : '0;
        busy_o    = in_busy;
        m_ack_o   = xfer_done ? grant_q : '0;
        m_rdata_o = '0;
        if (ack_hit) begin
            m_rdata_o = s_rdata_i;
        end else if (to_hit) begin
            m_rdata_o = ERR_DATA;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                end
            end
            ARB_BUSY: begin
                if (!(g_read | g_write)) begin
                    state_d = ARB_IDLE;
                end else if (xfer_done) begin
                    state_d  = ARB_DONE;
                    rr_ptr_d = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + IW'(1);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
